// File: rtl/branch_pkg.sv
// ============================================================================
// branch_pkg : shared kind encodings and FSM state encoding for branch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_COND = 2'b10;
  localparam logic [1:0] KIND_JUMP = 2'b11;

  // Wide enough for the largest legal FLUSH_CYC (15).
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FLAG = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_FLUSH     = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/branch_eval.sv
// ============================================================================
// branch_eval : combinational taken decision from branch kind and ALU flag
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_eval (
  input  logic [1:0] kind,
  input  logic       flag,
  output logic       taken
);

  assign taken = kind[1] & (kind[0] | flag);

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// branch_ctrl : branch-resolution sequencer (redirect + squash + stall).
// Optional statistics counters enabled by macro BRANCH_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 2
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_kind,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_valid,
  input  logic              flag,
  output logic              stall,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  ntaken_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYC - 1);

  state_e                  state_q, state_d;
  logic [1:0]              kind_q, kind_d;
  logic [ADDR_W-1:0]       target_q, target_d;
  logic [ADDR_W-1:0]       redirect_pc_q, redirect_pc_d;
  logic [FLUSH_CNT_W-1:0]  fcnt_q, fcnt_d;
  logic                    taken;

  branch_eval u_eval (
    .kind  (kind_q),
    .flag  (flag),
    .taken (taken)
  );

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    fcnt_d        = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          kind_d   = br_kind;
          target_d = br_target;
          if (br_kind == KIND_JUMP) begin
            state_d       = ST_REDIRECT;
            redirect_pc_d = br_target;
          end else if (br_kind == KIND_COND) begin
            state_d = ST_WAIT_FLAG;
          end
        end
      end
      ST_WAIT_FLAG: begin
        if (flag_valid) begin
          if (taken) begin
            state_d       = ST_REDIRECT;
            redirect_pc_d = target_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_REDIRECT: begin
        fcnt_d  = FLUSH_LOAD;
        state_d = (FLUSH_CYC == 1) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        // Counter holds the flush cycles still owed, this one included.
        if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q <= 1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_NONE;
      target_q      <= '0;
      redirect_pc_q <= '0;
      fcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign br_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign stall       = (state_q == ST_WAIT_FLAG);
  assign redirect    = (state_q == ST_REDIRECT);
  assign flush       = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
  assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

  // REDIRECT never follows itself, so a next state of REDIRECT is an entry.
  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if ((state_d == ST_REDIRECT) && (taken_cnt_q != '1))
      taken_cnt_d = taken_cnt_q + 1'b1;
    if ((state_q == ST_WAIT_FLAG) && flag_valid && !taken && (ntaken_cnt_q != '1))
      ntaken_cnt_d = ntaken_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// tb_branch_ctrl : directed bench for branch_ctrl (FLUSH_CYC=2 and =1 copies)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

  localparam int AW = 32;
  localparam int F0 = 2;
  localparam int F1 = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          br_valid;
  logic [1:0]    br_kind;
  logic [AW-1:0] br_target;
  logic          flag_valid;
  logic          flag;

  logic          rdy   [2];
  logic          stl   [2];
  logic          rdr   [2];
  logic [AW-1:0] pc    [2];
  logic          fls   [2];
  logic          bsy   [2];
`ifdef BRANCH_STATS_EN
  logic [15:0]   tcnt  [2];
  logic [15:0]   ncnt  [2];
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.ADDR_W(AW), .FLUSH_CYC(F0)) dut0 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy[0]),
    .br_kind(br_kind), .br_target(br_target), .flag_valid(flag_valid),
    .flag(flag), .stall(stl[0]), .redirect(rdr[0]), .redirect_pc(pc[0]),
    .flush(fls[0]), .busy(bsy[0])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tcnt[0]), .ntaken_cnt(ncnt[0])
`endif
  );

  branch_ctrl #(.ADDR_W(AW), .FLUSH_CYC(F1)) dut1 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy[1]),
    .br_kind(br_kind), .br_target(br_target), .flag_valid(flag_valid),
    .flag(flag), .stall(stl[1]), .redirect(rdr[1]), .redirect_pc(pc[1]),
    .flush(fls[1]), .busy(bsy[1])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tcnt[1]), .ntaken_cnt(ncnt[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: absolute cycle of each redirect; flush covers [redir, redir+F).
  int            cyc;
  int            redir_at [2];
  bit            waiting  [2];
  logic [AW-1:0] mtgt     [2];
  int            mtaken   [2];
  int            mntaken  [2];
  int            fc       [2];
  initial begin
    fc[0] = F0;
    fc[1] = F1;
  end

  function automatic bit m_flush(int i, int c);
    return (c >= redir_at[i]) && (c < redir_at[i] + fc[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        redir_at[i] <= -100;
        waiting[i]  <= 1'b0;
        mtgt[i]     <= '0;
        mtaken[i]   <= 0;
        mntaken[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!waiting[i] && !m_flush(i, cyc)) begin
          if (br_valid && br_kind == 2'b11) begin
            redir_at[i] <= cyc + 1;
            mtgt[i]     <= br_target;
            mtaken[i]   <= mtaken[i] + 1;
          end else if (br_valid && br_kind == 2'b10) begin
            waiting[i] <= 1'b1;
            mtgt[i]    <= br_target;
          end
        end else if (waiting[i] && flag_valid) begin
          waiting[i] <= 1'b0;
          if (flag) begin
            redir_at[i] <= cyc + 1;
            mtaken[i]   <= mtaken[i] + 1;
          end else begin
            mntaken[i] <= mntaken[i] + 1;
          end
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit ef = m_flush(i, cyc);
        automatic bit eb = waiting[i] || ef;
        chk($sformatf("d%0d redirect c%0d", i, cyc), 32'(rdr[i]), 32'(cyc == redir_at[i]));
        chk($sformatf("d%0d flush c%0d", i, cyc), 32'(fls[i]), 32'(ef));
        chk($sformatf("d%0d stall c%0d", i, cyc), 32'(stl[i]), 32'(waiting[i]));
        chk($sformatf("d%0d busy c%0d", i, cyc), 32'(bsy[i]), 32'(eb));
        chk($sformatf("d%0d br_ready c%0d", i, cyc), 32'(rdy[i]), 32'(!eb));
        if (cyc == redir_at[i])
          chk($sformatf("d%0d redirect_pc c%0d", i, cyc), pc[i], mtgt[i]);
`ifdef BRANCH_STATS_EN
        chk($sformatf("d%0d taken_cnt c%0d", i, cyc), 32'(tcnt[i]), 32'(mtaken[i]));
        chk($sformatf("d%0d ntaken_cnt c%0d", i, cyc), 32'(ncnt[i]), 32'(mntaken[i]));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_kind = 2'b00; br_target = '0;
    flag_valid = 1'b0; flag = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("reset br_ready", 32'(rdy[0]), 32'd1);
    chk("reset stall", 32'(stl[0]), 32'd0);
    chk("reset redirect", 32'(rdr[0]), 32'd0);
    chk("reset flush", 32'(fls[0]), 32'd0);
    chk("reset busy", 32'(bsy[0]), 32'd0);
    chk("reset redirect_pc", pc[0], 32'd0);

    // Unconditional jump
    br_valid = 1'b1; br_kind = 2'b11; br_target = 32'h0040_0100;
    step(); br_valid = 1'b0;
    chk("jump T+1 redirect", 32'(rdr[0]), 32'd1);
    chk("jump T+1 pc", pc[0], 32'h0040_0100);
    chk("jump T+1 flush", 32'(fls[0]), 32'd1);
    chk("jump T+1 stall", 32'(stl[0]), 32'd0);
    chk("jump T+1 f1 flush", 32'(fls[1]), 32'd1);
    step();
    chk("jump T+2 redirect", 32'(rdr[0]), 32'd0);
    chk("jump T+2 flush", 32'(fls[0]), 32'd1);
    chk("jump T+2 br_ready", 32'(rdy[0]), 32'd0);
    chk("jump T+2 f1 flush", 32'(fls[1]), 32'd0);
    chk("jump T+2 f1 br_ready", 32'(rdy[1]), 32'd1);
    step();
    chk("jump T+3 br_ready", 32'(rdy[0]), 32'd1);
    chk("jump T+3 flush", 32'(fls[0]), 32'd0);

    // Conditional taken, flag three cycles after accept
    br_valid = 1'b1; br_kind = 2'b10; br_target = 32'h0040_0200;
    step(); br_valid = 1'b0;
    chk("cond T+1 stall", 32'(stl[0]), 32'd1);
    chk("cond T+1 br_ready", 32'(rdy[0]), 32'd0);
    step();
    chk("cond T+2 stall", 32'(stl[0]), 32'd1);
    step();
    chk("cond T+3 stall", 32'(stl[0]), 32'd1);
    flag_valid = 1'b1; flag = 1'b1;
    step(); flag_valid = 1'b0; flag = 1'b0;
    chk("cond T+4 redirect", 32'(rdr[0]), 32'd1);
    chk("cond T+4 pc", pc[0], 32'h0040_0200);
    chk("cond T+4 stall", 32'(stl[0]), 32'd0);
    step();
    chk("cond T+5 flush", 32'(fls[0]), 32'd1);
    step();
    chk("cond T+6 br_ready", 32'(rdy[0]), 32'd1);
`ifdef BRANCH_STATS_EN
    chk("taken_cnt after cond", 32'(tcnt[0]), 32'd2);
`endif

    // Not taken; a flag offered in the accept cycle must be ignored
    br_valid = 1'b1; br_kind = 2'b10; br_target = 32'h0040_0280;
    flag_valid = 1'b1; flag = 1'b1;
    step(); br_valid = 1'b0; flag_valid = 1'b0;
    chk("ntaken T+1 stall", 32'(stl[0]), 32'd1);
    chk("ntaken T+1 redirect", 32'(rdr[0]), 32'd0);
    flag_valid = 1'b1; flag = 1'b0;
    step(); flag_valid = 1'b0;
    chk("ntaken T+2 stall", 32'(stl[0]), 32'd0);
    chk("ntaken T+2 redirect", 32'(rdr[0]), 32'd0);
    chk("ntaken T+2 flush", 32'(fls[0]), 32'd0);
    chk("ntaken T+2 busy", 32'(bsy[0]), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("ntaken_cnt", 32'(ncnt[0]), 32'd1);
`endif

    // Non-branch kinds retire silently
    br_valid = 1'b1; br_kind = 2'b01; br_target = 32'hDEAD_BEEF;
    step(); br_kind = 2'b00;
    chk("kind01 busy", 32'(bsy[0]), 32'd0);
    chk("kind01 pc held", pc[0], 32'h0040_0200);
    step(); br_valid = 1'b0;
    chk("kind00 br_ready", 32'(rdy[0]), 32'd1);
    chk("kind00 flush", 32'(fls[0]), 32'd0);

    // Jump descriptor held by decode through the flush
    br_valid = 1'b1; br_kind = 2'b11; br_target = 32'h0040_0400;
    step();
    chk("hold T+1 redirect", 32'(rdr[0]), 32'd1);
    step();
    chk("hold T+2 redirect", 32'(rdr[0]), 32'd0);
    chk("hold T+2 br_ready", 32'(rdy[0]), 32'd0);
    step();
    chk("hold T+3 br_ready", 32'(rdy[0]), 32'd1);
    step(); br_valid = 1'b0;
    chk("hold T+4 redirect", 32'(rdr[0]), 32'd1);
    step(); step();

    // Reset while waiting for the flag
    br_valid = 1'b1; br_kind = 2'b10; br_target = 32'h0040_0300;
    step(); br_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("rst wait stall", 32'(stl[0]), 32'd0);
    chk("rst wait busy", 32'(bsy[0]), 32'd0);
    chk("rst wait br_ready", 32'(rdy[0]), 32'd1);
    flag_valid = 1'b1; flag = 1'b1;
    step(); rst_n = 1'b1;
    step(); flag_valid = 1'b0; flag = 1'b0;
    chk("rst wait after redirect", 32'(rdr[0]), 32'd0);
    chk("rst wait after flush", 32'(fls[0]), 32'd0);

    // Reset in the middle of a flush
    br_valid = 1'b1; br_kind = 2'b11; br_target = 32'h0040_0500;
    step(); br_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("rst flush flush", 32'(fls[0]), 32'd0);
    chk("rst flush redirect_pc", pc[0], 32'd0);
    step(); rst_n = 1'b1;
    step();
    chk("rst flush after flush", 32'(fls[0]), 32'd0);
    chk("rst flush after redirect", 32'(rdr[0]), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rst taken_cnt", 32'(tcnt[0]), 32'd0);
`endif
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch-resolution sequencer for the MIPS pipeline.
- Accepts one branch/jump descriptor at a time from decode and waits for the ALU condition flag when needed.
- Evaluates taken = kind[1] & (kind[0] | flag).
- Sequences the PC redirect and the squash of wrong-path instructions, stalling fetch/decode while a conditional branch is unresolved.

Parameters:
- ADDR_W, 32: width of PC/target addresses.
- FLUSH_CYC, 2: cycles flush is held (wrong-path slots squashed); legal range 1..15.
- CNT_W, 16: width of statistics counters (used only with BRANCH_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  decode presents a branch descriptor
- br_ready  out  1  controller can accept a descriptor
- br_kind  in  2  00/01 = no branch, 10 = conditional, 11 = unconditional jump
- br_target  in  ADDR_W  branch/jump target PC
- flag_valid  in  1  ALU condition result valid this cycle
- flag  in  1  ALU condition result (e.g. equal/zero)
- stall  out  1  freeze fetch/decode while resolving
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  ADDR_W  target PC, valid when redirect=1
- flush  out  1  squash younger in-flight instructions
- busy  out  1  controller not in IDLE
- taken_cnt  out  CNT_W  taken branches (BRANCH_STATS_EN only)
- ntaken_cnt  out  CNT_W  not-taken conditional branches (BRANCH_STATS_EN only)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. On reset:
  - state=IDLE
  - all outputs 0 except br_ready=1
  - redirect_pc=0; latched kind/target=0; flush counter=0
- FSM states: IDLE, WAIT_FLAG, REDIRECT, FLUSH.
- IDLE:
  - br_ready=1, stall=0, busy=0.
  - Accept when br_valid & br_ready; latch br_kind and br_target.
  - kind[1]=0: no action, stay IDLE (descriptor retired).
  - kind=11: next state REDIRECT (redirect pulse 1 cycle after accept).
  - kind=10: next state WAIT_FLAG. flag_valid is ignored in IDLE, including the accept cycle; the ALU must present the flag at least 1 cycle later.
- WAIT_FLAG:
  - br_ready=0, stall=1, busy=1.
  - Stay until flag_valid=1; no timeout.
  - On flag_valid: evaluate taken with the latched kind. Taken goes to REDIRECT; not taken goes to IDLE with no redirect and no flush.
  - stall drops in the cycle after flag_valid.
- REDIRECT:
  - redirect=1 for exactly 1 cycle; redirect_pc=latched target; flush=1; stall=0; br_ready=0.
  - Load flush counter with FLUSH_CYC-1.
  - If FLUSH_CYC=1, go to IDLE; else go to FLUSH.
- FLUSH:
  - flush=1, br_ready=0; counter decrements each cycle.
  - When counter reaches 1, go to IDLE next edge.
  - Total flush high time = FLUSH_CYC cycles, including the REDIRECT cycle.
- Registering: all outputs are registered or decoded from the state register only; no combinational path from the inputs to redirect, flush or stall.
- Descriptor handling: br_valid while br_ready=0 is ignored (the descriptor is held by decode). Back-to-back accept is legal: a descriptor may be accepted in the same cycle FLUSH/WAIT_FLAG returns to IDLE only if it is already IDLE that cycle (br_ready is state-decoded).
- Reset mid-operation: aborts immediately with no redirect and no residual flush; a pending branch is lost (the pipeline is also reset).
- Target width: redirect_pc is a pure copy, with no arithmetic.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - taken_cnt increments on each REDIRECT entry (conditional-taken and unconditional).
  - ntaken_cnt increments on each not-taken conditional resolution.
  - Both counters saturate at 2^CNT_W-1 and reset to 0.
- Undefined: counters, ports and the CNT_W logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `branch_pkg`: kind encodings (KIND_NONE=2'b00, KIND_COND=2'b10, KIND_JUMP=2'b11) and the FSM state encoding (2-bit: IDLE=0, WAIT_FLAG=1, REDIRECT=2, FLUSH=3).
- One natural sub-module: `branch_eval`, combinational, taken = kind[1] & (kind[0] | flag), instantiated once in WAIT_FLAG decoding.
- The statistics counters stay inline.

Test Plan:
- Reset then idle, no stimulus -> br_ready=1; stall, redirect, flush, busy all 0; redirect_pc=0.
- Accept kind=11, target=0x0040_0100 at cycle T -> redirect=1 with redirect_pc=0x0040_0100 at T+1; flush high T+1..T+2 (FLUSH_CYC=2); br_ready=1 at T+3; stall never high.
- Accept kind=10, target=0x0040_0200; flag_valid=1, flag=1 three cycles later -> stall high for those 3 cycles; redirect pulse next cycle; flush 2 cycles; taken_cnt=1.
- Accept kind=10; flag_valid=1, flag=0 -> no redirect, no flush; back to IDLE 1 cycle after flag; ntaken_cnt=1. Also: flag_valid asserted in the accept cycle is ignored.
- Accept kind=01 and kind=00 -> stay IDLE, no outputs toggle, counters unchanged. Also: br_valid held during FLUSH -> not accepted until br_ready=1.
- Assert rst_n=0 mid-WAIT_FLAG and mid-FLUSH -> outputs clear asynchronously; no redirect after release. Also: FLUSH_CYC=1 build -> flush high only in the REDIRECT cycle.
